// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: shares the single L2 request port between the I-cache and D-cache miss paths.
// Define ARB_STATS_EN to add per-side grant counters (ic_grants/dc_grants).
module l2_req_arbiter #(
    parameter int ADDR_W       = 26,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_busy,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    output logic              dc_busy,
    output logic              dc_done,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_we,
    output logic              l2_src,
    input  logic              l2_ack
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       ic_grants,
    output logic [31:0]       dc_grants
`endif
);
    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t              state_q;
    logic                ic_v_q, dc_v_q, dc_we_q;
    logic [ADDR_W-1:0]   ic_addr_q, dc_addr_q;
    logic                l2_req_q, l2_we_q, l2_src_q, ic_done_q, dc_done_q;
    logic [ADDR_W-1:0]   l2_addr_q;
    logic [3:0]          starve_q, starve_d;
    logic                pick_d, grant, ack;

    always_comb begin
        pick_d   = dc_v_q && !(ic_v_q && starve_q == LIMIT);
        grant    = state_q == IDLE && (ic_v_q || dc_v_q);
        ack      = state_q == ISSUE && l2_ack;
        starve_d = !ic_v_q ? 4'd0 :
                   !grant  ? starve_q :
                   !pick_d ? 4'd0 :
                   starve_q + 4'(starve_q != LIMIT);
    end

    // Capture never collides with a clear: the winner's buffer is already valid, so it cannot load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ic_v_q    <= 1'b0;
            dc_v_q    <= 1'b0;
            dc_we_q   <= 1'b0;
            ic_addr_q <= '0;
            dc_addr_q <= '0;
        end else begin
            if (ic_req && !ic_v_q) begin
                ic_v_q    <= 1'b1;
                ic_addr_q <= ic_addr;
            end else if (ack && !l2_src_q) begin
                ic_v_q <= 1'b0;
            end
            if (dc_req && !dc_v_q) begin
                dc_v_q    <= 1'b1;
                dc_we_q   <= dc_we;
                dc_addr_q <= dc_addr;
            end else if (ack && l2_src_q) begin
                dc_v_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            l2_req_q  <= 1'b0;
            l2_addr_q <= '0;
            l2_we_q   <= 1'b0;
            l2_src_q  <= 1'b0;
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            starve_q  <= 4'd0;
        end else begin
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            starve_q  <= starve_d;
            if (grant) begin
                state_q   <= ISSUE;
                l2_req_q  <= 1'b1;
                l2_addr_q <= pick_d ? dc_addr_q : ic_addr_q;
                l2_we_q   <= pick_d && dc_we_q;
                l2_src_q  <= pick_d;
            end else if (ack) begin
                state_q   <= IDLE;
                l2_req_q  <= 1'b0;
                ic_done_q <= !l2_src_q;
                dc_done_q <= l2_src_q;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] ic_grants_q, dc_grants_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ic_grants_q <= '0;
            dc_grants_q <= '0;
        end else if (grant) begin
            ic_grants_q <= ic_grants_q + 32'(!pick_d);
            dc_grants_q <= dc_grants_q + 32'(pick_d);
        end
    end

    assign ic_grants = ic_grants_q;
    assign dc_grants = dc_grants_q;
`endif

    assign ic_busy = ic_v_q;
    assign dc_busy = dc_v_q;
    assign ic_done = ic_done_q;
    assign dc_done = dc_done_q;
    assign l2_req  = l2_req_q;
    assign l2_addr = l2_addr_q;
    assign l2_we   = l2_we_q;
    assign l2_src  = l2_src_q;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: directed vector table plus randomized traffic against a per-side buffer model.
// Grant counters are checked as well when ARB_STATS_EN is defined.
module tb_l2_req_arbiter;
    localparam int AW = 26;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, l2_ack = 1'b0;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0;
    logic          ic_busy, ic_done, dc_busy, dc_done, l2_req, l2_we, l2_src;
    logic [AW-1:0] l2_addr;
`ifdef ARB_STATS_EN
    logic [31:0]   ic_grants, dc_grants;
`endif

    l2_req_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_busy(ic_busy), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_busy(dc_busy), .dc_done(dc_done),
        .l2_req(l2_req), .l2_addr(l2_addr), .l2_we(l2_we), .l2_src(l2_src), .l2_ack(l2_ack)
`ifdef ARB_STATS_EN
        , .ic_grants(ic_grants), .dc_grants(dc_grants)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            r, ic, dc, dwe, ack;
        logic [AW-1:0] ia, da;
        logic [32:0]   exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0, n_err = 0;

    // Model: side 0 = I, side 1 = D; owner is the side holding the L2 port, -1 when idle.
    bit            pend[2];
    logic [AW-1:0] baddr[2];
    bit            bwe;
    int            owner = -1, waits = 0;
    bit            done[2];
    bit            e_req, e_src, e_we;
    logic [AW-1:0] e_addr;
    int unsigned   grants[2];

    function automatic vec_t v(bit r, bit ic, logic [AW-1:0] ia, bit dc, bit dwe, logic [AW-1:0] da, bit ack,
                               bit ib, bit id, bit db, bit dd, bit rq, bit src, bit we, logic [AW-1:0] a);
        vec_t t;
        t.r = r; t.ic = ic; t.ia = ia; t.dc = dc; t.dwe = dwe; t.da = da; t.ack = ack;
        t.exp = {ib, id, db, dd, rq, src, we, a};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [32:0] dut_vec();
        return {ic_busy, ic_done, dc_busy, dc_done, l2_req, l2_src, l2_we, l2_addr};
    endfunction

    task automatic model_edge(input bit r, input bit ic, input logic [AW-1:0] ia, input bit dc,
                              input bit dwe, input logic [AW-1:0] da, input bit ack);
        bit old[2];
        int w;
        if (r) begin
            pend = '{0, 0}; done = '{0, 0}; owner = -1; waits = 0;
            e_req = 0; e_src = 0; e_we = 0; e_addr = '0; grants = '{0, 0};
            return;
        end
        old = pend;
        done = '{0, 0};
        if (owner >= 0) begin
            if (ack) begin
                done[owner] = 1; pend[owner] = 0; owner = -1; e_req = 0;
            end
        end else if (old[0] || old[1]) begin
            w = (old[1] && !(old[0] && waits >= LIM)) ? 1 : 0;
            owner = w; e_req = 1; e_src = w[0]; e_addr = baddr[w]; e_we = (w == 1) && bwe;
            grants[w]++;
            waits = (w == 1) ? ((waits < LIM) ? waits + 1 : LIM) : 0;
        end
        if (!old[0]) waits = 0;
        if (ic && !old[0]) begin pend[0] = 1; baddr[0] = ia; end
        if (dc && !old[1]) begin pend[1] = 1; baddr[1] = da; bwe = dwe; end
    endtask

    task automatic step(input bit r, input bit ic, input logic [AW-1:0] ia, input bit dc,
                        input bit dwe, input logic [AW-1:0] da, input bit ack);
        reset = r; ic_req = ic; ic_addr = ia; dc_req = dc; dc_we = dwe; dc_addr = da; l2_ack = ack;
        @(posedge clk);
        model_edge(r, ic, ia, dc, dwe, da, ack);
        #1;
        chk("model", 64'(dut_vec()), 64'({pend[0], done[0], pend[1], done[1], e_req, e_src, e_we, e_addr}));
`ifdef ARB_STATS_EN
        chk("ic_grants", 64'(ic_grants), 64'(grants[0]));
        chk("dc_grants", 64'(dc_grants), 64'(grants[1]));
`endif
    endtask

    initial begin
        // reset state
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // single I request: l2_req for three cycles, done one cycle after ack
        tbl.push_back(v(0,1,'h1234,0,0,0,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,      1,0,0,0,1,0,0,'h1234));
        tbl.push_back(v(0,0,0,0,0,0,0,      1,0,0,0,1,0,0,'h1234));
        tbl.push_back(v(0,0,0,0,0,0,0,      1,0,0,0,1,0,0,'h1234));
        tbl.push_back(v(0,0,0,0,0,0,1,      0,1,0,0,0,0,0,'h1234));
        tbl.push_back(v(0,0,0,0,0,0,0,      0,0,0,0,0,0,0,'h1234));
        // simultaneous: D writeback first, I next after one idle cycle
        tbl.push_back(v(0,1,'h10,1,1,'h20,0, 1,0,1,0,0,0,0,'h1234));
        tbl.push_back(v(0,0,0,0,0,0,0,       1,0,1,0,1,1,1,'h20));
        tbl.push_back(v(0,0,0,0,0,0,1,       1,0,0,1,0,1,1,'h20));
        tbl.push_back(v(0,0,0,0,0,0,0,       1,0,0,0,1,0,0,'h10));
        tbl.push_back(v(0,0,0,0,0,0,1,       0,1,0,0,0,0,0,'h10));
        tbl.push_back(v(0,0,0,0,0,0,0,       0,0,0,0,0,0,0,'h10));
        // request while busy is dropped; stray ack in idle does nothing
        tbl.push_back(v(0,1,'h77,0,0,0,0, 1,0,0,0,0,0,0,'h10));
        tbl.push_back(v(0,1,'h55,0,0,0,0, 1,0,0,0,1,0,0,'h77));
        tbl.push_back(v(0,1,'h55,0,0,0,0, 1,0,0,0,1,0,0,'h77));
        tbl.push_back(v(0,0,0,0,0,0,1,    0,1,0,0,0,0,0,'h77));
        tbl.push_back(v(0,0,0,0,0,0,0,    0,0,0,0,0,0,0,'h77));
        tbl.push_back(v(0,0,0,0,0,0,1,    0,0,0,0,0,0,0,'h77));
        // D re-requests right after its done: the pending I request wins the next slot
        tbl.push_back(v(0,0,0,1,0,'h30,0,  0,0,1,0,0,0,0,'h77));
        tbl.push_back(v(0,1,'h40,0,0,0,0,  1,0,1,0,1,1,0,'h30));
        tbl.push_back(v(0,0,0,0,0,0,1,     1,0,0,1,0,1,0,'h30));
        tbl.push_back(v(0,0,0,1,0,'h31,0,  1,0,1,0,1,0,0,'h40));
        tbl.push_back(v(0,0,0,0,0,0,1,     0,1,1,0,0,0,0,'h40));
        tbl.push_back(v(0,0,0,0,0,0,0,     0,0,1,0,1,1,0,'h31));
        tbl.push_back(v(0,0,0,0,0,0,1,     0,0,0,1,0,1,0,'h31));
        tbl.push_back(v(0,0,0,0,0,0,0,     0,0,0,0,0,1,0,'h31));
        // reset mid-ISSUE, then a late ack
        tbl.push_back(v(0,0,0,1,1,'h3f,0,  0,0,1,0,0,1,0,'h31));
        tbl.push_back(v(0,0,0,0,0,0,0,     0,0,1,0,1,1,1,'h3f));
        tbl.push_back(v(1,1,'h99,0,0,0,0,  0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,     0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,1,     0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,     0,0,0,0,0,0,0,0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].ic, tbl[i].ia, tbl[i].dc, tbl[i].dwe, tbl[i].da, tbl[i].ack);
            chk($sformatf("vec%0d", i), 64'(dut_vec()), 64'(tbl[i].exp));
        end

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0, AW'($urandom),
                 $urandom_range(0, 3) == 0, 1'($urandom), AW'($urandom),
                 e_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
